matmul_engine: RTL and testbench
================================

Name: matmul_engine

Overview:
Parametrised NxN signed integer matrix-multiply engine. It is the hardware successor to the software 3x3 multiply the MIPS core currently runs.
- Host loads A and B element-by-element, pulses start, waits for done, then reads C element-by-element.
- One multiply-accumulate per cycle; sits beside the MIPS datapath as a memory-mapped coprocessor.

Parameters:
N, 3, matrix dimension (N >= 1)
DW, 32, element width in bits, signed two's complement
IW (localparam), max(1, clog2(N)), row/column index width

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write strobe for A/B element
wr_sel  in  1  0 = matrix A, 1 = matrix B
wr_row  in  IW  element row
wr_col  in  IW  element column
wr_data  in  DW  element value
start  in  1  begin multiply (level sampled, acts as pulse)
busy  out  1  computation in progress
done  out  1  one-cycle completion pulse
rd_en  in  1  read strobe for C element
rd_row  in  IW  C row
rd_col  in  IW  C column
rd_data  out  DW  C element, registered
rd_valid  out  1  rd_data valid this cycle

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; busy=0, done=0, rd_valid=0, rd_data=0.
  - All A, B, C elements and the accumulator cleared to 0.
  - i/j/k counters cleared to 0.
  - rst mid-CALC aborts immediately; no done pulse.
- States:
  - IDLE: start=1 → CALC, counters i=j=k=0, accumulator=0.
  - CALC: every cycle compute acc_next = acc + A[i][k]*B[k][j].
    - k<N-1: acc<=acc_next, k++.
    - k==N-1: C[i][j]<=acc_next, acc<=0, k=0, advance j; when j wraps, advance i.
    - After the last element (i=j=k=N-1) → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Timing:
  - busy=1 exactly in CALC cycles, i.e. N^3 cycles (27 for N=3).
  - done pulses in the cycle after the final MAC, with busy=0.
  - All C values are final when done=1.
- Arithmetic:
  - Full 2*DW signed product is truncated to low DW bits.
  - Accumulation wraps modulo 2^DW, matching MIPS addu/mul low-word semantics.
- Writes:
  - Accepted in IDLE and DONE only; ignored in CALC.
  - Any index >= N: write ignored.
  - Write in the same cycle start is sampled in IDLE: write is committed, and the computation sees the new value.
- start:
  - Ignored in CALC and DONE (no restart, no queueing).
  - A new start in IDLE recomputes all of C; previous C is overwritten element by element.
- Reads:
  - rd_en sampled any state; one-cycle latency: rd_valid=1 and rd_data=C[rd_row][rd_col] on the next cycle.
  - Reads during CALC return current contents (possibly old).
  - Out-of-range index → rd_data=0 with rd_valid=1.
  - rd_valid=0 when rd_en was 0; rd_data holds its last value.

Optional Feature:
MATMUL_OVF_FLAG_EN:
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - Sticky: set if any product or accumulation step overflows DW signed range.
  - Cleared on rst and on each accepted start.
  - Valid when done=1.
- Undefined: no ovf port, no detection logic; wrap behaviour identical.

Decomposition:
- Package matmul_pkg:
  - state enum (IDLE, CALC, DONE).
  - idx_width function computing IW.
  - Opcode constants wr_sel A=0 / B=1.
- One sub-module matmul_mac:
  - Holds the accumulator register.
  - Signed multiply/truncate/add, clear and load controls.
  - Overflow detect under MATMUL_OVF_FLAG_EN.
- Top holds the A/B/C arrays, counters and FSM.

Test Plan:
1. N=3: load A=B=[[1,2,3],[4,5,6],[7,8,9]], start → busy for 27 cycles, done pulse once; C=[[30,36,42],[66,81,96],[102,126,150]] via reads, each rd_valid one cycle after rd_en.
2. N=3: A=identity, B=[[-1,5,0],[2,-7,9],[100,0,-3]] → C==B; then start again without reload → identical C, second done pulse.
3. Overflow: A[0][0]=32'h7FFFFFFF, B[0][0]=2, all others 0 → C[0][0]=32'hFFFFFFFE; with MATMUL_OVF_FLAG_EN, ovf=1; after new start with A[0][0]=1, ovf=0.
4. Protocol: start pulsed at CALC cycle 5 and wr_en to A[0][0] at cycle 10 → ignored: still 27 busy cycles, one done, C matches pre-write A. Index row=3 write/read → no effect, rd_data=0.
5. rst asserted at CALC cycle 12 → next cycle busy=0, done never pulses, all C reads return 0; subsequent full load+start completes normally.
6. N=4, DW=16: A=all 2s, B=all 3s → 64 busy cycles, every C element=24.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the NxN matrix-multiply engine.
// Latency: n/a (types, constants and an elaboration-time function only).
// Backpressure: n/a.
//
// Contents: FSM state enum, A/B select codes, row/column index width helper.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // wr_sel encodings
    localparam logic WR_SEL_A = 1'b0;
    localparam logic WR_SEL_B = 1'b1;

    // Row/column index width: max(1, clog2(n)).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate slice with wrap-around (low DW bits) arithmetic.
// Latency: sum is combinational from a, b and acc; acc updates on the next clk edge.
// Backpressure: none; the caller steers acc via acc_clr / acc_ld every cycle.
//
// Ports: clk, rst (sync, active-high), acc_clr (acc <= 0, wins over acc_ld),
//        acc_ld (acc <= sum), a/b operands, sum = acc + a*b (truncated).
// Optional MATMUL_OVF_FLAG_EN: ovf_clr, ovf_chk (step is real), sticky ovf output.
module matmul_mac #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acc_clr,
    input  logic          acc_ld,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum
`ifdef MATMUL_OVF_FLAG_EN
    ,
    input  logic          ovf_clr,
    input  logic          ovf_chk,
    output logic          ovf
`endif
);

    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] prod;

`ifdef MATMUL_OVF_FLAG_EN
    logic [2*DW-1:0] prod_full;
    logic            prod_ovf;
    logic            add_ovf;
    logic            ovf_q, ovf_d;

    always_comb begin
        // Sign-extend both operands so the low 2*DW bits hold the exact signed product.
        prod_full = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
        prod      = prod_full[DW-1:0];
        sum       = acc_q + prod;
        // Product fits in DW signed iff bits [2DW-1:DW-1] are all equal.
        prod_ovf  = !((&prod_full[2*DW-1:DW-1]) || (~|prod_full[2*DW-1:DW-1]));
        // Addition overflows iff both addends share a sign the result does not.
        add_ovf   = (acc_q[DW-1] == prod[DW-1]) && (sum[DW-1] != acc_q[DW-1]);
        ovf_d     = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (ovf_chk && (prod_ovf || add_ovf)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    always_comb begin
        // Low DW bits of a signed product equal those of the unsigned product.
        prod = a * b;
        sum  = acc_q + prod;
    end
`endif

    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (acc_ld) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matmul_engine.sv
// NxN signed matrix-multiply coprocessor: C = A * B, one MAC per cycle, N^3 busy cycles.
// Latency: done pulses one cycle after the last MAC; reads return one cycle after rd_en.
// Backpressure: none; writes during CALC and start outside IDLE are silently dropped.
//
// Ports: clk, rst (sync, active-high); write port wr_en/wr_sel/wr_row/wr_col/wr_data;
//        start, busy, done; read port rd_en/rd_row/rd_col -> rd_data/rd_valid (registered).
// Optional MATMUL_OVF_FLAG_EN: adds sticky ovf output, cleared on rst and each accepted start.
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int  N  = 3,
    parameter int  DW = 32,
    localparam int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [IW-1:0] wr_row,
    input  logic [IW-1:0] wr_col,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          rd_en,
    input  logic [IW-1:0] rd_row,
    input  logic [IW-1:0] rd_col,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
`ifdef MATMUL_OVF_FLAG_EN
    ,
    output logic          ovf
`endif
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DW-1:0] a_q [N][N];
    logic [DW-1:0] a_d [N][N];
    logic [DW-1:0] b_q [N][N];
    logic [DW-1:0] b_d [N][N];
    logic [DW-1:0] c_q [N][N];
    logic [DW-1:0] c_d [N][N];
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    logic          acc_clr, acc_ld;
    logic [DW-1:0] mac_sum;
    logic          wr_ok, rd_ok;
`ifdef MATMUL_OVF_FLAG_EN
    logic          ovf_clr, ovf_chk;
`endif

    function automatic logic in_range(input logic [IW-1:0] idx);
        return int'(idx) < N;
    endfunction

    matmul_mac #(.DW(DW)) u_mac (
        .clk     (clk),
        .rst     (rst),
        .acc_clr (acc_clr),
        .acc_ld  (acc_ld),
        .a       (a_q[i_q][k_q]),
        .b       (b_q[k_q][j_q]),
        .sum     (mac_sum)
`ifdef MATMUL_OVF_FLAG_EN
        ,
        .ovf_clr (ovf_clr),
        .ovf_chk (ovf_chk),
        .ovf     (ovf)
`endif
    );

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        acc_clr    = 1'b0;
        acc_ld     = 1'b0;
`ifdef MATMUL_OVF_FLAG_EN
        ovf_clr    = 1'b0;
        ovf_chk    = 1'b0;
`endif
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        rd_ok      = in_range(rd_row) && in_range(rd_col);

        // Read port: C contents as they stand, zero for out-of-range indices.
        if (rd_en) begin
            rd_data_d = rd_ok ? c_q[rd_row][rd_col] : '0;
        end

        // Host writes land before a same-cycle start takes effect, so CALC sees them.
        wr_ok = wr_en && (state_q != CALC) && in_range(wr_row) && in_range(wr_col);
        if (wr_ok && (wr_sel == WR_SEL_A)) begin
            a_d[wr_row][wr_col] = wr_data;
        end
        if (wr_ok && (wr_sel == WR_SEL_B)) begin
            b_d[wr_row][wr_col] = wr_data;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_clr = 1'b1;
`ifdef MATMUL_OVF_FLAG_EN
                    ovf_clr = 1'b1;
`endif
                end
            end
            CALC: begin
`ifdef MATMUL_OVF_FLAG_EN
                ovf_chk = 1'b1;
`endif
                if (k_q != LAST) begin
                    acc_ld = 1'b1;
                    k_d    = k_q + 1'b1;
                end else begin
                    // Last term of the dot product goes straight into C.
                    c_d[i_q][j_q] = mac_sum;
                    acc_clr       = 1'b1;
                    k_d           = '0;
                    if (j_q != LAST) begin
                        j_d = j_q + 1'b1;
                    end else begin
                        j_d = '0;
                        if (i_q != LAST) begin
                            i_d = i_q + 1'b1;
                        end else begin
                            i_d     = '0;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                    c_q[r][c] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
        end
    end

    assign busy     = (state_q == CALC);
    assign done     = (state_q == DONE);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Bench for matmul_engine: N=3/DW=32 instance under random and directed stimulus,
// plus an N=4/DW=16 instance. Expected C comes from a plain-arithmetic matrix model.
module tb_matmul_engine;

    localparam int  N     = 3;
    localparam int  N4    = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, wr_sel, start, rd_en;
    logic [1:0]  wr_row, wr_col, rd_row, rd_col;
    logic [31:0] wr_data;
    logic        busy, done, rd_valid;
    logic [31:0] rd_data;

    logic        wr_en4, wr_sel4, start4, rd_en4;
    logic [1:0]  wr_row4, wr_col4, rd_row4, rd_col4;
    logic [15:0] wr_data4;
    logic        busy4, done4, rd_valid4;
    logic [15:0] rd_data4;
`ifdef MATMUL_OVF_FLAG_EN
    logic        ovf, ovf4;
    logic        movf;
`endif

    logic [31:0] ma [N][N];
    logic [31:0] mb [N][N];
    logic [31:0] mc [N][N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matmul_engine #(.N(N), .DW(32)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .rd_valid(rd_valid)
`ifdef MATMUL_OVF_FLAG_EN
        , .ovf(ovf)
`endif
    );

    matmul_engine #(.N(N4), .DW(16)) u_dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_sel(wr_sel4), .wr_row(wr_row4),
        .wr_col(wr_col4), .wr_data(wr_data4), .start(start4), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .rd_row(rd_row4), .rd_col(rd_col4), .rd_data(rd_data4),
        .rd_valid(rd_valid4)
`ifdef MATMUL_OVF_FLAG_EN
        , .ovf(ovf4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: C = A*B with products and sums wrapped to 32 bits.
    task automatic model_mul();
`ifdef MATMUL_OVF_FLAG_EN
        movf = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                logic [31:0] acc;
                longint      p, s;
                acc = '0;
                for (int k = 0; k < N; k++) begin
                    p = longint'($signed(ma[i][k])) * longint'($signed(mb[k][j]));
                    s = longint'($signed(acc)) + longint'($signed(p[31:0]));
`ifdef MATMUL_OVF_FLAG_EN
                    if (p > SMAX || p < SMIN) movf = 1'b1;
                    if (s > SMAX || s < SMIN) movf = 1'b1;
`endif
                    acc = s[31:0];
                end
                mc[i][j] = acc;
            end
        end
    endtask

    task automatic write_elem(input logic sel, input int r, input int c, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                write_elem(1'b0, i, j, ma[i][j]);
                write_elem(1'b1, i, j, mb[i][j]);
            end
        end
    endtask

    task automatic do_read(input int r, input int c, output logic v, output logic [31:0] d);
        rd_en = 1'b1; rd_row = 2'(r); rd_col = 2'(c);
        tick();
        v = rd_valid; d = rd_data;
        rd_en = 1'b0;
    endtask

    // Start, then run a fixed window of cycles counting busy/done; optional
    // injections (cycle index counted from the first CALC cycle, -1 = none).
    task automatic run_calc(input int start_at, input int wr_at, input int rst_at,
                            output int busy_cnt, output int done_cnt, output int done_bad);
        busy_cnt = 0; done_cnt = 0; done_bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0; wr_en = 1'b0;
        for (int c = 0; c < 36; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (busy) done_bad++;
            end
            if (c == start_at) start = 1'b1;
            if (c == wr_at) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 32'h5555;
            end
            if (c == rst_at) rst = 1'b1;
            tick();
            start = 1'b0; wr_en = 1'b0; rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic v; logic [31:0] d;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd_valid=%b rd_data=%0h, expected 0 0 0 0",
                     busy, done, rd_valid, rd_data);
        end
`ifdef MATMUL_OVF_FLAG_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b expected 0", ovf);
        end
`endif
        rst = 1'b0;
        tick();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                do_read(i, j, v, d);
                checks++;
                if (v !== 1'b1 || d !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_c[%0d][%0d]: got v=%b d=%0h expected v=1 d=0", i, j, v, d);
                end
            end
        end
    endtask

    task automatic check_c(input string tag);
        logic v; logic [31:0] d;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                do_read(i, j, v, d);
                checks++;
                if (v !== 1'b1 || d !== mc[i][j]) begin
                    errors++;
                    $display("FAIL %s_c[%0d][%0d]: got v=%b d=%0h expected v=1 d=%0h",
                             tag, i, j, v, d, mc[i][j]);
                end
            end
        end
    endtask

    task automatic test_basic();
        int bc, dc, db;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 32'(i * N + j + 1);
                mb[i][j] = 32'(i * N + j + 1);
            end
        load_all();
        run_calc(-1, -1, -1, bc, dc, db);
        checks++;
        if (bc != N * N * N || dc != 1 || db != 0) begin
            errors++;
            $display("FAIL basic_timing: got busy=%0d done=%0d done_with_busy=%0d expected %0d 1 0",
                     bc, dc, db, N * N * N);
        end
        model_mul();
        check_c("basic");
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== mc[N-1][N-1]) begin
            errors++;
            $display("FAIL basic_rd_hold: got v=%b d=%0h expected v=0 d=%0h", rd_valid, rd_data, mc[N-1][N-1]);
        end
    endtask

    task automatic test_identity();
        int bc, dc, db;
        int bv [N][N] = '{'{-1, 5, 0}, '{2, -7, 9}, '{100, 0, -3}};
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? 32'd1 : 32'd0;
                mb[i][j] = 32'(bv[i][j]);
            end
        load_all();
        model_mul();
        for (int rep = 0; rep < 2; rep++) begin
            run_calc(-1, -1, -1, bc, dc, db);
            checks++;
            if (bc != N * N * N || dc != 1 || db != 0) begin
                errors++;
                $display("FAIL identity_timing%0d: got busy=%0d done=%0d bad=%0d expected %0d 1 0",
                         rep, bc, dc, db, N * N * N);
            end
            check_c("identity");
        end
    endtask

    task automatic test_overflow();
        int bc, dc, db;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = '0; mb[i][j] = '0;
            end
        ma[0][0] = 32'h7FFFFFFF;
        mb[0][0] = 32'd2;
        load_all();
        run_calc(-1, -1, -1, bc, dc, db);
        model_mul();
        check_c("ovf");
`ifdef MATMUL_OVF_FLAG_EN
        checks++;
        if (ovf !== movf) begin
            errors++;
            $display("FAIL ovf_set: got %b expected %b", ovf, movf);
        end
`endif
        ma[0][0] = 32'd1;
        write_elem(1'b0, 0, 0, ma[0][0]);
        run_calc(-1, -1, -1, bc, dc, db);
        model_mul();
        check_c("ovf_clear");
`ifdef MATMUL_OVF_FLAG_EN
        checks++;
        if (ovf !== movf) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected %b", ovf, movf);
        end
`endif
    endtask

    task automatic test_protocol();
        int bc, dc, db;
        logic v; logic [31:0] d;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = $urandom_range(0, 200);
                mb[i][j] = $urandom_range(0, 200);
            end
        load_all();
        run_calc(5, 10, -1, bc, dc, db);
        checks++;
        if (bc != N * N * N || dc != 1 || db != 0) begin
            errors++;
            $display("FAIL protocol_timing: got busy=%0d done=%0d bad=%0d expected %0d 1 0",
                     bc, dc, db, N * N * N);
        end
        model_mul();
        check_c("protocol");
        write_elem(1'b0, 3, 0, 32'hDEAD);
        write_elem(1'b1, 0, 3, 32'hBEEF);
        do_read(3, 0, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL oob_read_row: got v=%b d=%0h expected v=1 d=0", v, d);
        end
        do_read(1, 3, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL oob_read_col: got v=%b d=%0h expected v=1 d=0", v, d);
        end
        run_calc(-1, -1, -1, bc, dc, db);
        check_c("oob_write");
    endtask

    task automatic test_reset_mid();
        int bc, dc, db;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = $urandom; mb[i][j] = $urandom;
            end
        load_all();
        run_calc(-1, -1, 12, bc, dc, db);
        checks++;
        if (bc != 13 || dc != 0) begin
            errors++;
            $display("FAIL reset_mid_abort: got busy=%0d done=%0d expected 13 0", bc, dc);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mc[i][j] = '0;
        check_c("reset_mid");
        load_all();
        run_calc(-1, -1, -1, bc, dc, db);
        checks++;
        if (bc != N * N * N || dc != 1) begin
            errors++;
            $display("FAIL reset_mid_rerun: got busy=%0d done=%0d expected %0d 1", bc, dc, N * N * N);
        end
        model_mul();
        check_c("reset_mid_rerun");
    endtask

    task automatic test_random();
        int bc, dc, db;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ma[i][j] = (r == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
                    mb[i][j] = (r == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
                end
            load_all();
            // New B[2][2] written in the same cycle start is sampled.
            mb[N-1][N-1] = $urandom;
            wr_en = 1'b1; wr_sel = 1'b1; wr_row = 2'(N - 1); wr_col = 2'(N - 1);
            wr_data = mb[N-1][N-1];
            // A write landing in the DONE cycle is accepted.
            run_calc(-1, N * N * N, -1, bc, dc, db);
            checks++;
            if (bc != N * N * N || dc != 1 || db != 0) begin
                errors++;
                $display("FAIL random_timing%0d: got busy=%0d done=%0d bad=%0d", r, bc, dc, db);
            end
            model_mul();
            check_c("random");
`ifdef MATMUL_OVF_FLAG_EN
            checks++;
            if (ovf !== movf) begin
                errors++;
                $display("FAIL random_ovf%0d: got %b expected %b", r, ovf, movf);
            end
`endif
            ma[0][0] = 32'h5555;
        end
        run_calc(-1, -1, -1, bc, dc, db);
        model_mul();
        check_c("done_write");
    endtask

    task automatic test_n4();
        int bc, dc, exp4;
        exp4 = 0;
        for (int k = 0; k < N4; k++) exp4 += 2 * 3;
        for (int i = 0; i < N4; i++)
            for (int j = 0; j < N4; j++) begin
                wr_en4 = 1'b1; wr_row4 = 2'(i); wr_col4 = 2'(j);
                wr_sel4 = 1'b0; wr_data4 = 16'd2; tick();
                wr_sel4 = 1'b1; wr_data4 = 16'd3; tick();
                wr_en4 = 1'b0;
            end
        start4 = 1'b1; tick(); start4 = 1'b0;
        bc = 0; dc = 0;
        for (int c = 0; c < 80; c++) begin
            if (busy4) bc++;
            if (done4) dc++;
            tick();
        end
        checks++;
        if (bc != N4 * N4 * N4 || dc != 1) begin
            errors++;
            $display("FAIL n4_timing: got busy=%0d done=%0d expected %0d 1", bc, dc, N4 * N4 * N4);
        end
`ifdef MATMUL_OVF_FLAG_EN
        checks++;
        if (ovf4 !== 1'b0) begin
            errors++;
            $display("FAIL n4_ovf: got %b expected 0", ovf4);
        end
`endif
        for (int i = 0; i < N4; i++)
            for (int j = 0; j < N4; j++) begin
                rd_en4 = 1'b1; rd_row4 = 2'(i); rd_col4 = 2'(j);
                tick();
                rd_en4 = 1'b0;
                checks++;
                if (rd_valid4 !== 1'b1 || rd_data4 !== 16'(exp4)) begin
                    errors++;
                    $display("FAIL n4_c[%0d][%0d]: got v=%b d=%0d expected v=1 d=%0d",
                             i, j, rd_valid4, rd_data4, exp4);
                end
            end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        start = 1'b0; rd_en = 1'b0; rd_row = '0; rd_col = '0;
        wr_en4 = 1'b0; wr_sel4 = 1'b0; wr_row4 = '0; wr_col4 = '0; wr_data4 = '0;
        start4 = 1'b0; rd_en4 = 1'b0; rd_row4 = '0; rd_col4 = '0;
        test_reset();
        test_basic();
        test_identity();
        test_overflow();
        test_protocol();
        test_reset_mid();
        test_random();
        test_n4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
